// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: return-address-stack sizing and the
// per-cycle operation selected by the stack's request arbitration.
package riscv_pkg;

  localparam int RAS_DEPTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    RAS_OP_NONE,
    RAS_OP_PUSH,
    RAS_OP_POP,
    RAS_OP_POP_THEN_PUSH,
    RAS_OP_RESTORE
  } ras_op_e;

endpackage

// File: rtl/riscv_ras_mem.sv
// Return-address storage: one synchronous write port, one asynchronous read
// port. Contents are intentionally not reset; the stack masks empty reads.
module riscv_ras_mem #(
  parameter int ADDR_WIDTH = 64,
  parameter int RAS_DEPTH  = 16,
  parameter int PTR_WIDTH  = $clog2(RAS_DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [PTR_WIDTH-1:0]  i_waddr,
  input  logic [ADDR_WIDTH-1:0] i_wdata,
  input  logic [PTR_WIDTH-1:0]  i_raddr,
  output logic [ADDR_WIDTH-1:0] o_rdata
);

  logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/riscv_ras_stack.sv
// Circular return-address stack with push / pop / pop-then-push, one
// checkpoint snapshot of (tos, count), and abort-restore of that snapshot.
module riscv_ras_stack
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int RAS_DEPTH  = RAS_DEPTH_DEFAULT,
  parameter int PTR_WIDTH  = $clog2(RAS_DEPTH)
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  enable,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic                  i_pop_then_push,
  input  logic [ADDR_WIDTH-1:0] i_push_addr,
  input  logic                  i_checkpoint,
  input  logic                  i_abort,
  output logic [ADDR_WIDTH-1:0] o_top_addr,
  output logic                  o_valid,
  output logic                  o_full,
  output logic [PTR_WIDTH:0]    o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [PTR_WIDTH:0]   CNT_FULL  = (PTR_WIDTH+1)'(RAS_DEPTH);
  localparam logic [PTR_WIDTH-1:0] TOS_RESET = PTR_WIDTH'(RAS_DEPTH - 1);

  ras_op_e                op;
  logic [PTR_WIDTH-1:0]   tos_q, tos_d, snap_tos_q, snap_tos_d;
  logic [PTR_WIDTH:0]     count_q, count_d, snap_count_q, snap_count_d;
  logic                   overflow_q, overflow_d, underflow_q, underflow_d;
  logic                   mem_we_req, mem_we;
  logic [PTR_WIDTH-1:0]   mem_waddr;
  logic [ADDR_WIDTH-1:0]  mem_rdata;
  logic                   empty, full;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // One operation per enabled cycle; lower-priority requests are dropped.
  always_comb begin
    op = RAS_OP_NONE;
    if (enable) begin
      if (i_abort)              op = RAS_OP_RESTORE;
      else if (i_pop_then_push) op = RAS_OP_POP_THEN_PUSH;
      else if (i_push)          op = RAS_OP_PUSH;
      else if (i_pop)           op = RAS_OP_POP;
    end
  end

  always_comb begin
    tos_d        = tos_q;
    count_d      = count_q;
    snap_tos_d   = snap_tos_q;
    snap_count_d = snap_count_q;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    mem_we_req   = 1'b0;
    mem_waddr    = tos_q;

    // Snapshot captures the pre-operation state; the operation still runs.
    if (enable && i_checkpoint && !i_abort) begin
      snap_tos_d   = tos_q;
      snap_count_d = count_q;
    end

    case (op)
      RAS_OP_PUSH, RAS_OP_POP_THEN_PUSH: begin
        if (op == RAS_OP_POP_THEN_PUSH && !empty) begin
          mem_we_req = 1'b1;
          mem_waddr  = tos_q;
        end else begin
          tos_d      = tos_q + 1'b1;
          mem_we_req = 1'b1;
          mem_waddr  = tos_q + 1'b1;
          if (full) overflow_d = 1'b1;
          else      count_d    = count_q + 1'b1;
        end
      end
      RAS_OP_POP: begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          tos_d   = tos_q - 1'b1;
          count_d = count_q - 1'b1;
        end
      end
      RAS_OP_RESTORE: begin
        tos_d   = snap_tos_q;
        count_d = snap_count_q;
      end
      default: ;
    endcase
  end

  // A write racing an asserted reset is discarded along with the rest of the request.
  assign mem_we = mem_we_req & nreset;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tos_q        <= TOS_RESET;
      count_q      <= '0;
      snap_tos_q   <= TOS_RESET;
      snap_count_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      tos_q        <= tos_d;
      count_q      <= count_d;
      snap_tos_q   <= snap_tos_d;
      snap_count_q <= snap_count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  riscv_ras_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAS_DEPTH  (RAS_DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (mem_we),
    .i_waddr (mem_waddr),
    .i_wdata (i_push_addr),
    .i_raddr (tos_q),
    .o_rdata (mem_rdata)
  );

  assign o_top_addr  = empty ? '0 : mem_rdata;
  assign o_valid     = !empty;
  assign o_full      = full;
  assign o_count     = count_q;
  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

endmodule

// File: doc/riscv_ras_stack.md
RISCV_RAS_STACK -- requirements
Module: riscv_ras_stack

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, width of stored return addresses.
REQ-002 SHALL have parameter RAS_DEPTH, default 16, entry count, power of two, >= 2.
REQ-003 SHALL have parameter PTR_WIDTH, default $clog2(RAS_DEPTH), width of the top-of-stack pointer.
REQ-004 SHALL have ports: clk input 1, sole clock, rising edge; nreset input 1, asynchronous active-low reset.
REQ-005 SHALL have ports: enable input 1, global state-update gate; i_push input 1; i_pop input 1; i_pop_then_push input 1; i_push_addr input ADDR_WIDTH, address written on push or pop_then_push.
REQ-006 SHALL have ports: i_checkpoint input 1, snapshot request; i_abort input 1, restore request.
REQ-007 SHALL have ports: o_top_addr output ADDR_WIDTH, predicted return address; o_valid output 1, stack non-empty; o_full output 1; o_count output PTR_WIDTH+1, live entries.
REQ-008 SHALL have ports: o_overflow output 1, one-cycle pulse; o_underflow output 1, one-cycle pulse.

Function
REQ-009 SHALL store entries in a circular array indexed by top pointer tos; tos increment/decrement wraps modulo RAS_DEPTH.
REQ-010 SHALL apply at most one operation per enabled cycle, priority abort > pop_then_push > push > pop; lower-priority requests that cycle are dropped.
REQ-011 push: tos <= tos+1, mem[tos+1] <= i_push_addr, count <= min(count+1, RAS_DEPTH).
REQ-012 push while count == RAS_DEPTH: oldest entry overwritten, count stays RAS_DEPTH, o_overflow = 1 next cycle.
REQ-013 pop while count > 0: tos <= tos-1, count <= count-1; entry contents unchanged.
REQ-014 pop while count == 0: no state change, o_underflow = 1 next cycle.
REQ-015 pop_then_push while count > 0: mem[tos] <= i_push_addr, tos and count unchanged; while count == 0: identical to push.
REQ-016 i_checkpoint (no abort same cycle): snapshot registers <= current pre-operation tos and count; the same-cycle operation still executes.
REQ-017 i_abort: tos and count <= snapshot values; memory contents not restored; coincident push/pop/pop_then_push/checkpoint ignored.
REQ-018 All state updates visible on outputs the cycle after the request edge (latency 1); no combinational path from request inputs to outputs.
REQ-019 o_top_addr = mem[tos] when count > 0, else all zeros.
REQ-020 o_valid = (count != 0); o_full = (count == RAS_DEPTH); o_count = count.
REQ-021 o_overflow/o_underflow SHALL be registered, high exactly one cycle per event, else 0.
REQ-022 enable low: no state change, requests ignored (including abort, checkpoint), pulse outputs 0, other outputs hold.

Reset
REQ-023 nreset low SHALL asynchronously set tos = RAS_DEPTH-1, count = 0, snapshot tos = RAS_DEPTH-1, snapshot count = 0.
REQ-024 During and after reset: o_top_addr = 0, o_valid = 0, o_full = 0, o_count = 0, o_overflow = 0, o_underflow = 0.
REQ-025 Memory array SHALL NOT be reset; masking by REQ-019 guarantees no stale output.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight request; first post-reset push writes index 0.

Structure
REQ-027 RAS_DEPTH default and an op-select enum (NONE, PUSH, POP, POP_THEN_PUSH, RESTORE) SHALL reside in riscv_pkg.
REQ-028 Single flat module; optional sub-module riscv_ras_mem (storage array, one write port, one async read port) permitted.
REQ-029 Module SHALL consume the push/pop/pop_then_push outputs of the RAS arbitration stage unmodified.

Verification
REQ-030 Reset, push 0x1000, 0x2000, 0x3000 -> o_count 3, o_top_addr 0x3000; pop -> 0x2000; pop, pop -> o_valid 0, o_top_addr 0.
REQ-031 Push 17 addresses 0x100..0x1100 step 0x100 (DEPTH 16) -> o_overflow pulses once on 17th, o_count 16, top 0x1100; 16 pops return 0x1100..0x200, 17th pop pulses o_underflow.
REQ-032 Push 0xA0, pop_then_push 0xB0 -> count 1, top 0xB0; pop_then_push on empty with 0xC0 -> count 1, top 0xC0.
REQ-033 Push 0x10, 0x20, checkpoint with push 0x30, push 0x40, abort -> count 2, top 0x20.
REQ-034 Push and pop asserted same cycle at count 2 -> push only, count 3; abort with push same cycle -> push ignored.
REQ-035 enable low with push 0x50 -> no change; nreset pulse mid-sequence at count 5 -> all outputs 0, next push lands at index 0.
